noc_packetizer: RTL and testbench
=================================

NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 The block SHALL have parameter WIDTH_packet, default 57, giving the network packet width.
REQ-002 The block SHALL have parameter WIDTH_payload, default 40, giving the PE payload width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2), giving the number of entries in the packet queue.
REQ-004 The block SHALL have parameters MY_X, default 0 (3 bit), and MY_Y, default 0 (2 bit), giving this node's mesh coordinates.
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-006 Ports SHALL be as follows:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  PE send request
- req_ready  out  1  block accepts the request
- req_dst_x  in  3  destination x
- req_dst_y  in  2  destination y
- req_payload  in  WIDTH_payload  data to send
- pkt_valid  out  1  packet available to the router PE input
- pkt_ready  in  1  router PE input accepts the packet
- pkt_data  out  WIDTH_packet  formatted packet
- drop_pulse  out  1  self-addressed request discarded

Function
REQ-007 A request SHALL be accepted on any rising clk edge where req_valid and req_ready are both 1.
REQ-008 req_ready SHALL equal "queue not full"; it SHALL NOT depend on pkt_ready in the same cycle.
REQ-009 Packet format SHALL be:
- [39:0] payload
- [41:40] y hop = |dst_y−MY_Y|
- [44:42] x hop = |dst_x−MY_X|
- [45] y dir: 1 = north, when dst_y > MY_Y, else 0
- [46] x dir: 1 = east, when dst_x > MY_X, else 0
- [49:47] src x = MY_X
- [51:50] src y = MY_Y
- [54:52] dst x
- [56:55] dst y
REQ-010 The hop and direction fields SHALL be computed combinationally at acceptance, and the full packet SHALL be written to the queue on the same edge.
REQ-011 A request with dst equal to (MY_X, MY_Y) SHALL be accepted but not queued; drop_pulse SHALL be 1 for exactly the following cycle.
REQ-012 The output state machine SHALL have two states, IDLE and SEND.
- IDLE: if the queue is non-empty, load the head into the output register, pop it, and go to SEND.
- SEND: on pkt_valid && pkt_ready, reload from the queue head if non-empty and stay in SEND; otherwise go to IDLE.
REQ-013 pkt_valid SHALL be 1 exactly in SEND.
REQ-014 pkt_data SHALL remain stable while pkt_valid is 1 and pkt_ready is 0.
REQ-015 Minimum latency SHALL be that pkt_valid rises on the second rising edge after the accepting edge.
REQ-016 Sustained throughput SHALL be one packet per cycle while pkt_ready is held at 1.
REQ-017 A simultaneous push and pop SHALL leave the queue count unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 Packets SHALL leave in acceptance order, with no loss and no duplication.

Reset
REQ-019 While rst_n is 0:
- req_ready = 0
- pkt_valid = 0
- pkt_data = 0
- drop_pulse = 0
- state = IDLE
- pointers and count = 0
REQ-020 Reset mid-transfer SHALL discard all queued and in-flight packets.
REQ-021 req_ready SHALL rise on the first rising edge after rst_n deasserts.

Configuration
REQ-022 With NI_DROP_CNT_EN defined, the block SHALL add output drop_cnt (16 bit).
- It is reset to 0.
- It increments on every drop.
- It saturates at 0xFFFF.
REQ-023 Without NI_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; drop_pulse SHALL be unaffected.

Structure
REQ-024 A shared package noc_pkg SHALL hold:
- WIDTH_packet and WIDTH_payload
- the field bit-position constants
- the pe_pkt_t packed struct
- the out_state_t enum (IDLE, SEND)
REQ-025 The queue SHALL be a sub-module, noc_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, din, dout), instantiated once.

Verification
REQ-026 With MY=(2,1), sending dst (5,0) with payload 0xABCDEF0123 SHALL give:
- pkt_data[46:40] = x dir 1, y dir 0, x hop 3, y hop 1
- [56:47] = dst (5,0), src (2,1)
- pkt_valid asserted 2 edges after acceptance
REQ-027 With MY=(2,1), dst (0,3) SHALL give x dir 0, x hop 2, y dir 1, y hop 2.
REQ-028 With MY=(2,1), dst (2,1) SHALL give drop_pulse for 1 cycle, no pkt_valid, and drop_cnt = 1 when NI_DROP_CNT_EN is defined.
REQ-029 With pkt_ready held at 0, sending 5 requests SHALL:
- accept 4, then hold req_ready = 0
- keep pkt_data frozen on packet 1
- on pkt_ready = 1, deliver all packets in order with one pkt_valid per cycle
REQ-030 Sending 8 back-to-back requests with pkt_ready = 1 SHALL yield 8 consecutive pkt_valid cycles, with the pointers wrapping.
REQ-031 Asserting rst_n = 0 with 3 packets queued and pkt_valid = 1 SHALL:
- drop all outputs to 0 immediately
- produce no stale packet after release

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packetizer slice.
// Holds the default widths, the bit positions of every packet field, the
// packed packet struct and the output state machine encoding.
package noc_pkg;

    localparam int unsigned WIDTH_packet  = 57;
    localparam int unsigned WIDTH_payload = 40;

    // Field bit positions inside a packet
    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned Y_HOP_LSB   = 40;
    localparam int unsigned X_HOP_LSB   = 42;
    localparam int unsigned Y_DIR_BIT   = 45;
    localparam int unsigned X_DIR_BIT   = 46;
    localparam int unsigned SRC_X_LSB   = 47;
    localparam int unsigned SRC_Y_LSB   = 50;
    localparam int unsigned DST_X_LSB   = 52;
    localparam int unsigned DST_Y_LSB   = 55;

    typedef struct packed {
        logic [1:0]               dst_y;
        logic [2:0]               dst_x;
        logic [1:0]               src_y;
        logic [2:0]               src_x;
        logic                     x_dir;
        logic                     y_dir;
        logic [2:0]               x_hop;
        logic [1:0]               y_hop;
        logic [WIDTH_payload-1:0] payload;
    } pe_pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

    // Unsigned |a - b| on 3-bit coordinates
    function automatic logic [2:0] abs_diff3(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO used as the packetizer's packet queue.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, din    write request and data (ignored when full)
//   pop          read request (ignored when empty); dout shows the head entry
//   full, empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 57,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Network interface packetizer: turns PE send requests into mesh packets.
// Each accepted request is formatted (hop counts, directions, source and
// destination coordinates, payload) and queued; an IDLE/SEND machine streams
// the queue head to the router through a registered valid/ready output.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          PE request handshake
//   req_dst_x, req_dst_y         destination coordinates
//   req_payload                  data to send
//   pkt_valid/pkt_ready          router-side handshake
//   pkt_data                     formatted packet
//   drop_pulse                   one-cycle pulse after a self-addressed request
//   drop_cnt                     saturating drop counter (only with NI_DROP_CNT_EN)
// Build option: define NI_DROP_CNT_EN to add the drop_cnt output and counter.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH_packet  = noc_pkg::WIDTH_packet,
    parameter int unsigned WIDTH_payload = noc_pkg::WIDTH_payload,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [2:0]  MY_X          = 3'd0,
    parameter logic [1:0]  MY_Y          = 2'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_dst_x,
    input  logic [1:0]               req_dst_y,
    input  logic [WIDTH_payload-1:0] req_payload,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [WIDTH_packet-1:0]  pkt_data,
    output logic                     drop_pulse
`ifdef NI_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    out_state_t r_state;
    pe_pkt_t    r_pkt;
    logic       r_rdy_en;
    logic       r_drop_pulse;
    logic [OCC_W-1:0] r_occ;

    logic                    w_accept;
    logic                    w_self;
    logic                    w_push;
    logic                    w_hs;
    logic                    w_queue_full;
    logic [2:0]              w_x_hop;
    logic [1:0]              w_y_hop;
    logic [WIDTH_packet-1:0] w_pkt_bits;
    logic [WIDTH_packet-1:0] w_fifo_dout;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_pop;

    // The output register is the head slot of the packet queue, so the total
    // number of undelivered packets (FIFO plus output register) is capped at
    // FIFO_DEPTH. r_rdy_en keeps req_ready low until the first edge after reset.
    assign w_queue_full = w_fifo_full | (r_occ == OCC_W'(FIFO_DEPTH));
    assign req_ready    = r_rdy_en & ~w_queue_full;

    assign w_accept = req_valid & req_ready;
    assign w_self   = (req_dst_x == MY_X) && (req_dst_y == MY_Y);
    assign w_push   = w_accept & ~w_self;
    assign w_hs     = (r_state == SEND) & pkt_ready;

    // IDLE pops whenever data is present; SEND pops only on a handshake
    assign w_fifo_pop = ~w_fifo_empty & ((r_state == IDLE) | pkt_ready);

    assign w_x_hop = abs_diff3(req_dst_x, MY_X);
    assign w_y_hop = 2'(abs_diff3({1'b0, req_dst_y}, {1'b0, MY_Y}));

    always_comb begin
        w_pkt_bits                                = '0;
        w_pkt_bits[PAYLOAD_LSB +: WIDTH_payload]  = req_payload;
        w_pkt_bits[Y_HOP_LSB +: 2]                = w_y_hop;
        w_pkt_bits[X_HOP_LSB +: 3]                = w_x_hop;
        w_pkt_bits[Y_DIR_BIT]                     = (req_dst_y > MY_Y);
        w_pkt_bits[X_DIR_BIT]                     = (req_dst_x > MY_X);
        w_pkt_bits[SRC_X_LSB +: 3]                = MY_X;
        w_pkt_bits[SRC_Y_LSB +: 2]                = MY_Y;
        w_pkt_bits[DST_X_LSB +: 3]                = req_dst_x;
        w_pkt_bits[DST_Y_LSB +: 2]                = req_dst_y;
    end

    noc_sync_fifo #(
        .WIDTH (WIDTH_packet),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_fifo_pop),
        .din   (w_pkt_bits),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pkt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_pkt   <= w_fifo_dout;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (pkt_ready) begin
                        if (!w_fifo_empty) begin
                            r_pkt <= w_fifo_dout;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en     <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_occ        <= '0;
        end else begin
            r_rdy_en     <= 1'b1;
            r_drop_pulse <= w_accept & w_self;
            case ({w_push, w_hs})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign pkt_valid  = (r_state == SEND);
    assign pkt_data   = r_pkt;
    assign drop_pulse = r_drop_pulse;

`ifdef NI_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_self && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Self-checking bench for noc_packetizer with node coordinates (2,1).
// Expected packets come from a field-level model built from the packet
// format rules; a queue of outstanding packets acts as the scoreboard.
module tb_noc_packetizer;

    localparam int MY_X = 2;
    localparam int MY_Y = 1;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_dst_x;
    logic [1:0]  req_dst_y;
    logic [39:0] req_payload;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [56:0] pkt_data;
    logic        drop_pulse;
`ifdef NI_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int vectors;
    int miscompares;
    logic [56:0] exp_q[$];

    noc_packetizer #(
        .WIDTH_packet  (57),
        .WIDTH_payload (40),
        .FIFO_DEPTH    (DEPTH),
        .MY_X          (3'(MY_X)),
        .MY_Y          (2'(MY_Y))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dst_x   (req_dst_x),
        .req_dst_y   (req_dst_y),
        .req_payload (req_payload),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
        .drop_pulse  (drop_pulse)
`ifdef NI_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Packet the node should emit for a request, from the format rules
    function automatic logic [56:0] model_pkt(input logic [2:0] dx, input logic [1:0] dy,
                                              input logic [39:0] pl);
        int xd;
        int yd;
        logic [2:0] xh;
        logic [1:0] yh;
        xd = int'(dx) - MY_X;
        yd = int'(dy) - MY_Y;
        xh = 3'((xd < 0) ? -xd : xd);
        yh = 2'((yd < 0) ? -yd : yd);
        return {dy, dx, 2'(MY_Y), 3'(MY_X), (xd > 0), (yd > 0), xh, yh, pl};
    endfunction

    function automatic logic [39:0] rand_payload();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_dst_x = '0;
        req_dst_y = '0;
        req_payload = '0;
        pkt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b0 || pkt_valid !== 1'b0 || drop_pulse !== 1'b0) begin
            $display("FAIL reset_ctrl: ready=%b valid=%b drop=%b, required 0 0 0",
                     req_ready, pkt_valid, drop_pulse);
            miscompares++;
        end
        vectors++;
        if (pkt_data !== 57'd0) begin
            $display("FAIL reset_data: got %h, required 0", pkt_data);
            miscompares++;
        end
`ifdef NI_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 16'd0) begin
            $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
            miscompares++;
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            $display("FAIL ready_before_edge: got %b, required 0", req_ready);
            miscompares++;
        end
        next_cycle();
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_after_edge: got %b, required 1", req_ready);
            miscompares++;
        end
    endtask

    // One directed request; checks latency and the named field values
    task automatic send_and_check(input string name, input logic [2:0] dx, input logic [1:0] dy,
                                  input logic [39:0] pl, input logic [6:0] route_bits);
        logic [56:0] exp;
        exp = model_pkt(dx, dy, pl);
        pkt_ready = 1'b0;
        req_valid = 1'b1;
        req_dst_x = dx;
        req_dst_y = dy;
        req_payload = pl;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL %s_ready: got %b, required 1", name, req_ready);
            miscompares++;
        end
        next_cycle();  // accepting edge
        req_valid = 1'b0;
        vectors++;
        if (pkt_valid !== 1'b0) begin
            $display("FAIL %s_early_valid: got %b, required 0", name, pkt_valid);
            miscompares++;
        end
        next_cycle();  // second edge counting the accepting one
        vectors++;
        if (pkt_valid !== 1'b1 || pkt_data !== exp) begin
            $display("FAIL %s_packet: valid=%b data=%h, required 1 %h", name, pkt_valid,
                     pkt_data, exp);
            miscompares++;
        end
        vectors++;
        if (pkt_data[46:40] !== route_bits || pkt_data[56:47] !== {dy, dx, 2'(MY_Y), 3'(MY_X)})
        begin
            $display("FAIL %s_fields: route=%b addr=%b, required %b %b", name, pkt_data[46:40],
                     pkt_data[56:47], route_bits, {dy, dx, 2'(MY_Y), 3'(MY_X)});
            miscompares++;
        end
        pkt_ready = 1'b1;
        next_cycle();
        pkt_ready = 1'b0;
        vectors++;
        if (pkt_valid !== 1'b0) begin
            $display("FAIL %s_release: valid=%b, required 0", name, pkt_valid);
            miscompares++;
        end
    endtask

    task automatic test_format();
        // x east, hop 3; y south, hop 1
        send_and_check("fmt_5_0", 3'd5, 2'd0, 40'hABCDEF0123, 7'b1_0_011_01);
        // x west, hop 2; y north, hop 2
        send_and_check("fmt_0_3", 3'd0, 2'd3, rand_payload(), 7'b0_1_010_10);
    endtask

    task automatic test_drop();
        req_valid = 1'b1;
        req_dst_x = 3'(MY_X);
        req_dst_y = 2'(MY_Y);
        req_payload = rand_payload();
        next_cycle();
        req_valid = 1'b0;
        vectors++;
        if (drop_pulse !== 1'b1 || pkt_valid !== 1'b0) begin
            $display("FAIL drop_pulse: drop=%b valid=%b, required 1 0", drop_pulse, pkt_valid);
            miscompares++;
        end
        next_cycle();
        vectors++;
        if (drop_pulse !== 1'b0 || pkt_valid !== 1'b0) begin
            $display("FAIL drop_width: drop=%b valid=%b, required 0 0", drop_pulse, pkt_valid);
            miscompares++;
        end
`ifdef NI_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 16'd1) begin
            $display("FAIL drop_cnt: got %0d, required 1", drop_cnt);
            miscompares++;
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [2:0]  dx[5];
        logic [1:0]  dy[5];
        logic [39:0] pl[5];
        logic [56:0] exp[5];
        int acc;
        int got;
        for (int i = 0; i < 5; i++) begin
            dx[i] = 3'(MY_X + 1 + i);  // never self-addressed
            dy[i] = 2'($urandom_range(0, 3));
            pl[i] = rand_payload();
            exp[i] = model_pkt(dx[i], dy[i], pl[i]);
        end
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            pkt_ready = (cyc >= 8);
            req_valid = (acc < 5);
            if (acc < 5) begin
                req_dst_x = dx[acc];
                req_dst_y = dy[acc];
                req_payload = pl[acc];
            end
            #1;
            if (cyc >= 2 && cyc < 8) begin
                vectors++;
                if (pkt_valid !== 1'b1 || pkt_data !== exp[0]) begin
                    $display("FAIL bp_hold c%0d: valid=%b data=%h, required 1 %h", cyc,
                             pkt_valid, pkt_data, exp[0]);
                    miscompares++;
                end
            end
            if (cyc == 7) begin
                vectors++;
                if (acc != 4 || req_ready !== 1'b0) begin
                    $display("FAIL bp_full: accepted=%0d ready=%b, required 4 0", acc, req_ready);
                    miscompares++;
                end
            end
            if (cyc >= 8 && cyc < 13) begin
                vectors++;
                if (pkt_valid !== 1'b1 || pkt_data !== exp[cyc-8]) begin
                    $display("FAIL bp_drain c%0d: valid=%b data=%h, required 1 %h", cyc,
                             pkt_valid, pkt_data, exp[cyc-8]);
                    miscompares++;
                end
            end
            if (pkt_valid && pkt_ready) got++;
            if (req_valid && req_ready) acc++;
            next_cycle();
        end
        req_valid = 1'b0;
        pkt_ready = 1'b0;
        vectors++;
        if (got != 5 || acc != 5 || pkt_valid !== 1'b0) begin
            $display("FAIL bp_total: delivered=%0d accepted=%0d valid=%b, required 5 5 0", got,
                     acc, pkt_valid);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [56:0] exp[8];
        pkt_ready = 1'b1;
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc < 8) begin
                req_valid = 1'b1;
                req_dst_x = 3'($urandom_range(3, 7));
                req_dst_y = 2'($urandom_range(0, 3));
                req_payload = rand_payload();
                exp[cyc] = model_pkt(req_dst_x, req_dst_y, req_payload);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (cyc < 8) begin
                vectors++;
                if (req_ready !== 1'b1) begin
                    $display("FAIL b2b_ready c%0d: got %b, required 1", cyc, req_ready);
                    miscompares++;
                end
            end
            if (cyc >= 2 && cyc < 10) begin
                vectors++;
                if (pkt_valid !== 1'b1 || pkt_data !== exp[cyc-2]) begin
                    $display("FAIL b2b_out c%0d: valid=%b data=%h, required 1 %h", cyc,
                             pkt_valid, pkt_data, exp[cyc-2]);
                    miscompares++;
                end
            end
            if (cyc == 10) begin
                vectors++;
                if (pkt_valid !== 1'b0) begin
                    $display("FAIL b2b_end: valid=%b, required 0", pkt_valid);
                    miscompares++;
                end
            end
            next_cycle();
        end
        pkt_ready = 1'b0;
    endtask

    task automatic test_random();
        logic exp_drop;
        logic stalled;
        logic [56:0] held;
        exp_q.delete();
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = ($urandom_range(0, 99) < 65);
            req_dst_x = 3'($urandom_range(0, 7));
            req_dst_y = 2'($urandom_range(0, 3));
            req_payload = rand_payload();
            pkt_ready = ($urandom_range(0, 99) < 55);
            #1;
            vectors++;
            if (req_ready !== (exp_q.size() < DEPTH)) begin
                $display("FAIL rnd_ready c%0d: got %b, outstanding=%0d", cyc, req_ready,
                         exp_q.size());
                miscompares++;
            end
            if (stalled) begin
                vectors++;
                if (pkt_valid !== 1'b1 || pkt_data !== held) begin
                    $display("FAIL rnd_stable c%0d: valid=%b data=%h, required 1 %h", cyc,
                             pkt_valid, pkt_data, held);
                    miscompares++;
                end
            end
            if (pkt_valid && pkt_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_extra c%0d: got %h, required no packet", cyc, pkt_data);
                    miscompares++;
                end else if (pkt_data !== exp_q[0]) begin
                    $display("FAIL rnd_data c%0d: got %h, required %h", cyc, pkt_data, exp_q[0]);
                    miscompares++;
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            exp_drop = 1'b0;
            if (req_valid && req_ready) begin
                if (req_dst_x == 3'(MY_X) && req_dst_y == 2'(MY_Y)) exp_drop = 1'b1;
                else exp_q.push_back(model_pkt(req_dst_x, req_dst_y, req_payload));
            end
            stalled = pkt_valid && !pkt_ready;
            held = pkt_data;
            next_cycle();
            vectors++;
            if (drop_pulse !== exp_drop) begin
                $display("FAIL rnd_drop c%0d: got %b, required %b", cyc, drop_pulse, exp_drop);
                miscompares++;
            end
        end
        req_valid = 1'b0;
        pkt_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (pkt_valid) begin
                vectors++;
                if (exp_q.size() == 0 || pkt_data !== exp_q[0]) begin
                    $display("FAIL rnd_drain: got %h, outstanding=%0d", pkt_data, exp_q.size());
                    miscompares++;
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            next_cycle();
        end
        vectors++;
        if (exp_q.size() != 0 || pkt_valid !== 1'b0) begin
            $display("FAIL rnd_lost: outstanding=%0d valid=%b, required 0 0", exp_q.size(),
                     pkt_valid);
            miscompares++;
        end
        pkt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [56:0] exp;
        int seen;
        pkt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_dst_x = 3'(4 + i);
            req_dst_y = 2'(i);
            req_payload = rand_payload();
            next_cycle();
        end
        req_valid = 1'b0;
        next_cycle();
        vectors++;
        if (pkt_valid !== 1'b1 || req_ready !== 1'b0) begin
            $display("FAIL mid_setup: valid=%b ready=%b, required 1 0", pkt_valid, req_ready);
            miscompares++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pkt_valid !== 1'b0 || req_ready !== 1'b0 || drop_pulse !== 1'b0 ||
            pkt_data !== 57'd0) begin
            $display("FAIL mid_reset: valid=%b ready=%b drop=%b data=%h, required all 0",
                     pkt_valid, req_ready, drop_pulse, pkt_data);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            next_cycle();
            if (pkt_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL mid_stale: stale valid cycles=%0d, required 0", seen);
            miscompares++;
        end
        req_valid = 1'b1;
        req_dst_x = 3'd7;
        req_dst_y = 2'd2;
        req_payload = rand_payload();
        exp = model_pkt(req_dst_x, req_dst_y, req_payload);
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        vectors++;
        if (pkt_valid !== 1'b1 || pkt_data !== exp) begin
            $display("FAIL mid_fresh: valid=%b data=%h, required 1 %h", pkt_valid, pkt_data, exp);
            miscompares++;
        end
        next_cycle();
        vectors++;
        if (pkt_valid !== 1'b0) begin
            $display("FAIL mid_single: valid=%b, required 0", pkt_valid);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_format();
        test_drop();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
